pipelined_cla_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit for the KGP-RISC ALU datapath. It generalises the 8-bit carry-lookahead adder to WIDTH bits by chaining SLICE-bit CLA slices, with one pipeline stage per slice. It has a valid/ready handshake, add/sub modes and condition flags (carry, overflow, zero, negative). It sustains one operation per cycle.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/cla_slice.sv | 53 +++++
 rtl/pipelined_cla_addsub.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the KGP-RISC ALU add/subtract datapath.
//   SLICE_W   - default number of bits resolved by one carry-lookahead slice
//   flags_t   - packed condition flags {cout, ovf, zero, neg}
//   op_mode_e - arithmetic mode of the add/sub unit (ADD, SUB)
package alu_pkg;

  localparam int SLICE_W = 8;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_mode_e;

endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead adder slice.
// Ports:
//   a, b   - slice operands (b already inverted by the caller for subtraction)
//   cin    - carry into bit 0 of the slice
//   s      - slice sum
//   cout   - carry out of the slice MSB
//   c_msb  - carry into the slice MSB (used for signed overflow)
//   zero   - slice sum is all zeros
module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb,
  output logic             zero
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic             run;

  // Each carry is expanded into its flat lookahead form,
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, so no carry depends on
  // another carry and the slice depth stays at two levels of logic.
  always_comb begin
    // NOTE: every variable written here gets a value before any conditional
    // use, otherwise synthesis would infer a latch to hold the old value.
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    run  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i];
      run    = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      c[i+1] = c[i+1] | (run & cin);
    end
  end

  assign s     = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];
  assign zero  = ~|s;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit pipelined add/subtract unit built from
// NSLICE chained cla_slice instances, one pipeline stage per slice.
// Latency NSLICE cycles, one beat per cycle, valid/ready on both sides.
// Optional macro ADDER_SAT_EN adds a per-beat 'sat' input that clamps the
// result to the signed extreme on overflow.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid, in_ready   - operand handshake (in_ready is combinational from out_ready)
//   op_a, op_b, sub, cin - operands, mode (1 = A-B) and add-mode carry-in
//   sat                  - (ADDER_SAT_EN only) saturate this beat on overflow
//   out_valid, out_ready - result handshake
//   sum, cout, ovf, zero, neg - result and condition flags
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
`ifdef ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int LAST   = NSLICE - 1;

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
    $error("pipelined_cla_addsub: WIDTH must be a nonzero multiple of SLICE");
  end

  op_mode_e         mode;
  logic             advance;

  // Stage inputs: stage 0 is fed from the ports, stage k from register k-1.
  logic             v_i   [NSLICE];
  logic             c_i   [NSLICE];
  logic             z_i   [NSLICE];
  logic             sat_i [NSLICE];
  logic [WIDTH-1:0] a_i   [NSLICE];
  logic [WIDTH-1:0] b_i   [NSLICE];
  logic [WIDTH-1:0] s_i   [NSLICE];

  // Stage results before registering.
  logic             c_o   [NSLICE];
  logic             cm_o  [NSLICE];
  logic             z_o   [NSLICE];
  logic [WIDTH-1:0] s_o   [NSLICE];

  // Stage registers: a/b carry the not-yet-used upper slices forward,
  // s carries the finished lower slices, c the carry into the next slice.
  logic             v_q   [NSLICE];
  logic             c_q   [NSLICE];
  logic             z_q   [NSLICE];
  logic             sat_q [NSLICE];
  logic [WIDTH-1:0] a_q   [NSLICE];
  logic [WIDTH-1:0] b_q   [NSLICE];
  logic [WIDTH-1:0] s_q   [NSLICE];

  flags_t           flg_d;
  flags_t           flg_q;
  logic [WIDTH-1:0] sum_d;

  assign mode = sub ? SUB : ADD;

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    logic [SLICE-1:0] slice_s;
    logic             slice_z;

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + 1: invert B once at entry, force carry-in.
      assign v_i[k] = in_valid;
      assign c_i[k] = (mode == SUB) | cin;
      assign z_i[k] = 1'b1;
      assign a_i[k] = op_a;
      assign b_i[k] = (mode == SUB) ? ~op_b : op_b;
      assign s_i[k] = '0;
`ifdef ADDER_SAT_EN
      assign sat_i[k] = sat;
`else
      assign sat_i[k] = 1'b0;
`endif
    end else begin : g_body
      assign v_i[k]   = v_q[k-1];
      assign c_i[k]   = c_q[k-1];
      assign z_i[k]   = z_q[k-1];
      assign sat_i[k] = sat_q[k-1];
      assign a_i[k]   = a_q[k-1];
      assign b_i[k]   = b_q[k-1];
      assign s_i[k]   = s_q[k-1];
    end

    cla_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a     (a_i[k][k*SLICE +: SLICE]),
      .b     (b_i[k][k*SLICE +: SLICE]),
      .cin   (c_i[k]),
      .s     (slice_s),
      .cout  (c_o[k]),
      .c_msb (cm_o[k]),
      .zero  (slice_z)
    );

    assign z_o[k] = z_i[k] & slice_z;
    // Slices above k are still zero in s_i, so OR-ing the new slice in place
    // is equivalent to a part-select write.
    assign s_o[k] = s_i[k] | (WIDTH'(slice_s) << (k * SLICE));
  end

  // Final stage: flags and optional clamp. Signed overflow only happens when
  // both effective operand MSBs agree, so A's MSB gives the true sign.
  always_comb begin
    flg_d.cout = c_o[LAST];
    flg_d.ovf  = cm_o[LAST] ^ c_o[LAST];
    sum_d      = s_o[LAST];
    if (sat_i[LAST] && flg_d.ovf) begin
      sum_d = {a_i[LAST][WIDTH-1], {(WIDTH-1){~a_i[LAST][WIDTH-1]}}};
    end
    flg_d.zero = (sat_i[LAST] && flg_d.ovf) ? 1'b0 : z_o[LAST];
    flg_d.neg  = sum_d[WIDTH-1];
  end

  // The whole pipe moves as one: it stalls only when a result is waiting
  // at the output and downstream refuses it.
  assign advance  = !v_q[LAST] || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's old value, giving a true shift per edge.
    if (!rst_n) begin
      // NOTE: the data arrays are reset too, not just the valid bits, so the
      // output port reads all-zero after reset.
      for (int k = 0; k < NSLICE; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        z_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
      flg_q <= '0;
    end else if (advance) begin
      for (int k = 0; k < NSLICE; k++) begin
        v_q[k]   <= v_i[k];
        c_q[k]   <= c_o[k];
        z_q[k]   <= z_o[k];
        sat_q[k] <= sat_i[k];
        a_q[k]   <= a_i[k];
        b_q[k]   <= b_i[k];
        s_q[k]   <= (k == LAST) ? sum_d : s_o[k];
      end
      flg_q <= flg_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = flg_q.cout;
  assign ovf       = flg_q.ovf;
  assign zero      = flg_q.zero;
  assign neg       = flg_q.neg;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed self-checking bench for pipelined_cla_addsub.
// Instantiates a 32-bit unit (4 stages) and an 8-bit unit (1 stage).
// Build with +define+ADDER_SAT_EN to also exercise saturation.
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, cin, out_valid, out_ready;
  logic        cout, ovf, zero, neg;
  logic [31:0] op_a, op_b, sum;
`ifdef ADDER_SAT_EN
  logic        sat;
`endif

  logic        n_in_valid, n_in_ready, n_sub, n_cin, n_out_valid, n_out_ready;
  logic        n_cout, n_ovf, n_zero, n_neg;
  logic [7:0]  n_op_a, n_op_b, n_sum;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    logic [31:0] exp_sum;
    logic [3:0]  exp_flags;  // {cout, ovf, zero, neg}
  } vec_t;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
`ifdef ADDER_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  pipelined_cla_addsub #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .op_a      (n_op_a),
    .op_b      (n_op_b),
    .sub       (n_sub),
    .cin       (n_cin),
`ifdef ADDER_SAT_EN
    .sat       (1'b0),
`endif
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .sum       (n_sum),
    .cout      (n_cout),
    .ovf       (n_ovf),
    .zero      (n_zero),
    .neg       (n_neg)
  );

  // Issue one beat on the 32-bit unit and wait (bounded) for its result.
  // Starts and ends just after a rising edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic c, output logic [31:0] res,
                       output logic [3:0] fl, output int lat);
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = sum;
    fl  = {cout, ovf, zero, neg};
    @(posedge clk); #1;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic c, output logic [7:0] res,
                        output logic [3:0] fl, output int lat);
    n_op_a = a; n_op_b = b; n_sub = s; n_cin = c; n_in_valid = 1'b1; n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    lat = 1;
    while (!n_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = n_sum;
    fl  = {n_cout, n_ovf, n_zero, n_neg};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
    checks++; if ({cout, ovf, zero, neg} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cout, ovf, zero, neg}); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", n_out_valid); end
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_arith;
    vec_t        v [9];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010};
    v[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b1100};
    v[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 4'b1010};
    v[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101};
    v[4] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0004, 4'b0000};
    v[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 4'b1000};
    v[6] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 4'b0000};
    v[7] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0001};
    v[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1110};
    for (int i = 0; i < 9; i++) begin
      do_op(v[i].a, v[i].b, v[i].s, v[i].c, r, f, lat);
      checks++; if (r !== v[i].exp_sum) begin errors++; $display("FAIL arith[%0d]_sum: got %h expected %h", i, r, v[i].exp_sum); end
      checks++; if (f !== v[i].exp_flags) begin errors++; $display("FAIL arith[%0d]_flags: got %b expected %b", i, f, v[i].exp_flags); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL arith[%0d]_latency: got %0d expected 4", i, lat); end
    end
  endtask

`ifdef ADDER_SAT_EN
  task automatic test_sat;
    vec_t        v [3];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b0100};
    v[1] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 4'b1101};
    v[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0000, 4'b1101};
    sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].a, v[i].b, v[i].s, v[i].c, r, f, lat);
      checks++; if (r !== v[i].exp_sum) begin errors++; $display("FAIL sat[%0d]_sum: got %h expected %h", i, r, v[i].exp_sum); end
      checks++; if (f !== v[i].exp_flags) begin errors++; $display("FAIL sat[%0d]_flags: got %b expected %b", i, f, v[i].exp_flags); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL sat[%0d]_latency: got %0d expected 4", i, lat); end
    end
    // Non-overflowing beat with sat=1 must be untouched.
    do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, r, f, lat);
    checks++; if (r !== 32'h0000_0030) begin errors++; $display("FAIL sat_no_ovf_sum: got %h expected 00000030", r); end
    sat = 1'b0;
  endtask
`endif

  task automatic test_narrow;
    logic [7:0] r;
    logic [3:0] f;
    int         lat;
    do_op8(8'h80, 8'h01, 1'b1, 1'b0, r, f, lat);
    checks++; if (r !== 8'h7F) begin errors++; $display("FAIL narrow_sub_sum: got %h expected 7f", r); end
    checks++; if (f !== 4'b1100) begin errors++; $display("FAIL narrow_sub_flags: got %b expected 1100", f); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL narrow_sub_latency: got %0d expected 1", lat); end
    do_op8(8'hFF, 8'h00, 1'b0, 1'b1, r, f, lat);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL narrow_add_sum: got %h expected 00", r); end
    checks++; if (f !== 4'b1010) begin errors++; $display("FAIL narrow_add_flags: got %b expected 1010", f); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL narrow_add_latency: got %0d expected 1", lat); end
  endtask

  // valid 1,0,1 at the input must come out as valid 1,0,1 four edges later.
  task automatic test_bubble;
    logic [7:0]  obs;
    logic [31:0] vals [8];
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0; op_b = 32'h0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0 || c == 2);
      op_a     = 32'(c + 1);
      @(posedge clk); #1;
      obs[c]  = out_valid;
      vals[c] = sum;
    end
    in_valid = 1'b0;
    checks++; if (obs !== 8'b0010_1000) begin errors++; $display("FAIL bubble_valid_pattern: got %b expected 00101000", obs); end
    checks++; if (vals[3] !== 32'h1) begin errors++; $display("FAIL bubble_first_sum: got %h expected 00000001", vals[3]); end
    checks++; if (vals[5] !== 32'h3) begin errors++; $display("FAIL bubble_second_sum: got %h expected 00000003", vals[5]); end
  endtask

  task automatic test_back_to_back;
    int          cyc = 0;
    int          tx  = 0;
    int          rx  = 0;
    int          dup = 0;
    logic        stall;
    logic        acc;
    logic [31:0] exp;
    sub = 1'b0; cin = 1'b0;
    while (rx < 8 && cyc < 60) begin
      stall     = (cyc >= 5 && cyc <= 7);
      out_ready = !stall;
      in_valid  = (tx < 8);
      op_a      = 32'(tx);
      op_b      = 32'(tx) << 24;
      @(negedge clk);
      checks++; if (in_ready !== !stall) begin errors++; $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", cyc, in_ready, !stall); end
      acc = in_valid && in_ready;
      exp = 32'(rx) + (32'(rx) << 24);
      if (out_valid && stall) begin
        checks++; if (sum !== exp) begin errors++; $display("FAIL b2b_hold cycle %0d: got %h expected %h", cyc, sum, exp); end
      end
      if (out_valid && out_ready) begin
        checks++; if (sum !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", rx, sum, exp); end
        rx++;
      end
      @(posedge clk); #1;
      if (acc) tx++;
      cyc++;
    end
    checks++; if (rx !== 8) begin errors++; $display("FAIL b2b_count: got %0d results expected 8", rx); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) dup++;
    end
    @(posedge clk); #1;
    checks++; if (dup !== 0) begin errors++; $display("FAIL b2b_no_duplicate: got %0d extra results expected 0", dup); end
  endtask

  // Reset with three beats in flight: nothing may emerge afterwards.
  task automatic test_reset_flush;
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0; op_b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op_a     = 32'(100 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid cycle %0d: got %b expected 0", i, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_op_a = '0; n_op_b = '0; n_sub = 1'b0; n_cin = 1'b0;
`ifdef ADDER_SAT_EN
    sat = 1'b0;
`endif
    test_reset;
    test_arith;
`ifdef ADDER_SAT_EN
    test_sat;
`endif
    test_narrow;
    test_bubble;
    test_back_to_back;
    test_reset_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
